// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer pointer manager.
// The optional FB_DROP_CNT_EN build adds a saturating dropped-frame counter.
package fb_pkg;

    localparam int unsigned FB_BUF_CNT     = 3;
    localparam logic [31:0] FB_FRAME_BYTES = 32'h0020_0000;
    localparam int unsigned FB_IDX_W       = $clog2(FB_BUF_CNT);
    localparam int unsigned FB_DROP_CNT_W  = 16;

    typedef logic [FB_IDX_W-1:0] buf_idx_t;

    typedef enum logic [1:0] {
        EV_IDLE     = 2'b00,
        EV_WR_DONE  = 2'b01,
        EV_RD_START = 2'b10,
        EV_BOTH     = 2'b11
    } fb_event_e;

    function automatic fb_event_e fb_decode_event(input logic wr_done, input logic rd_start);
        return fb_event_e'({rd_start, wr_done});
    endfunction

endpackage

// File: rtl/fb_free_idx_find.sv
// Combinational priority finder: lowest buffer index equal to neither excluded index.
// Always finds one as long as BUF_CNT >= 3.
module fb_free_idx_find
    import fb_pkg::*;
#(
    parameter  int unsigned BUF_CNT = FB_BUF_CNT,
    localparam int unsigned IDX_W   = $clog2(BUF_CNT)
) (
    input  logic [IDX_W-1:0] excl_a,
    input  logic [IDX_W-1:0] excl_b,
    output logic [IDX_W-1:0] free_idx
);

    // Scanning downward lets the lowest qualifying index win the last assignment.
    always_comb begin
        free_idx = '0;
        for (int i = int'(BUF_CNT) - 1; i >= 0; i--) begin
            if ((IDX_W'(i) != excl_a) && (IDX_W'(i) != excl_b)) begin
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fb_buf_ptr_ctrl.sv
// N-buffer rotation manager in the read clock domain; indices and base addresses are registered.
// Define FB_DROP_CNT_EN to add the drop_cnt_o saturating dropped-frame counter.
module fb_buf_ptr_ctrl
    import fb_pkg::*;
#(
    parameter  int unsigned BUF_CNT     = FB_BUF_CNT,
    parameter  int unsigned ADDR_W      = 32,
    parameter  logic [31:0] FRAME_BYTES = FB_FRAME_BYTES,
    localparam int unsigned IDX_W       = $clog2(BUF_CNT)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_done_stb_i,
    input  logic              rd_start_stb_i,
    output logic [IDX_W-1:0]  wr_idx_o,
    output logic [IDX_W-1:0]  rd_idx_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o,
`ifdef FB_DROP_CNT_EN
    output logic [FB_DROP_CNT_W-1:0] drop_cnt_o,
`endif
    output logic              new_frame_o
);

    logic [IDX_W-1:0]  wr_idx, rd_idx, latest_idx;
    logic              latest_valid;
    logic [IDX_W-1:0]  wr_idx_nxt, rd_idx_nxt, latest_idx_nxt;
    logic              latest_valid_nxt;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [IDX_W-1:0]  free_rd_wr, free_wr_only;
    fb_event_e         ev;

    function automatic logic [ADDR_W-1:0] base_of(input logic [IDX_W-1:0] idx);
        return ADDR_W'(idx) * ADDR_W'(FRAME_BYTES);
    endfunction

    fb_free_idx_find #(.BUF_CNT(BUF_CNT)) u_free_rd_wr (
        .excl_a   (rd_idx),
        .excl_b   (wr_idx),
        .free_idx (free_rd_wr)
    );

    // On a forwarded frame the reader takes the old write buffer, so only that one is excluded.
    fb_free_idx_find #(.BUF_CNT(BUF_CNT)) u_free_wr_only (
        .excl_a   (wr_idx),
        .excl_b   (wr_idx),
        .free_idx (free_wr_only)
    );

    assign ev = fb_decode_event(wr_done_stb_i, rd_start_stb_i);

    always_comb begin
        wr_idx_nxt       = wr_idx;
        rd_idx_nxt       = rd_idx;
        latest_idx_nxt   = latest_idx;
        latest_valid_nxt = latest_valid;
        unique case (ev)
            EV_WR_DONE: begin
                latest_idx_nxt   = wr_idx;
                latest_valid_nxt = 1'b1;
                wr_idx_nxt       = free_rd_wr;
            end
            EV_RD_START: begin
                if (latest_valid) begin
                    rd_idx_nxt       = latest_idx;
                    latest_valid_nxt = 1'b0;
                end
            end
            EV_BOTH: begin
                rd_idx_nxt       = wr_idx;
                latest_valid_nxt = 1'b0;
                wr_idx_nxt       = free_wr_only;
            end
            default: ;
        endcase
    end

    // Addresses load from the next index so they change in the same cycle as the index.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_idx       <= IDX_W'(1);
            rd_idx       <= '0;
            latest_idx   <= '0;
            latest_valid <= 1'b0;
            wr_addr      <= base_of(IDX_W'(1));
            rd_addr      <= '0;
        end else begin
            wr_idx       <= wr_idx_nxt;
            rd_idx       <= rd_idx_nxt;
            latest_idx   <= latest_idx_nxt;
            latest_valid <= latest_valid_nxt;
            wr_addr      <= base_of(wr_idx_nxt);
            rd_addr      <= base_of(rd_idx_nxt);
        end
    end

    assign wr_idx_o    = wr_idx;
    assign rd_idx_o    = rd_idx;
    assign wr_addr_o   = wr_addr;
    assign rd_addr_o   = rd_addr;
    assign new_frame_o = latest_valid;

`ifdef FB_DROP_CNT_EN
    logic [FB_DROP_CNT_W-1:0] drop_cnt;

    // Any write completion while an unread frame is pending discards that frame.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            drop_cnt <= '0;
        end else if (wr_done_stb_i && latest_valid && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + FB_DROP_CNT_W'(1);
        end
    end

    assign drop_cnt_o = drop_cnt;
`endif

    a_wr_ne_rd : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        wr_idx != rd_idx);

    a_latest_distinct : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        latest_valid |-> ((latest_idx != wr_idx) && (latest_idx != rd_idx)));

endmodule

// File: tb/tb_fb_buf_ptr_ctrl.sv
// Randomized and directed bench for fb_buf_ptr_ctrl with BUF_CNT=3 and BUF_CNT=4 instances.
// Checks against a rule-level reference model; define FB_DROP_CNT_EN to also check drop_cnt_o.
module tb_fb_buf_ptr_ctrl;

    localparam logic [31:0] STRIDE = 32'h0020_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_done;
    logic        rd_start;
    logic [1:0]  wr_idx_s   [2];
    logic [1:0]  rd_idx_s   [2];
    logic [31:0] wr_addr_s  [2];
    logic [31:0] rd_addr_s  [2];
    logic        new_frame_s[2];
`ifdef FB_DROP_CNT_EN
    logic [15:0] drop_cnt_s [2];
`endif

    int total_checks = 0;
    int bad_checks   = 0;

    int          buf_cnt   [2] = '{3, 4};
    int          m_wr      [2];
    int          m_rd      [2];
    int          m_latest  [2];
    bit          m_valid   [2];
    int          m_drops   [2];

    always #5 clk = ~clk;

    fb_buf_ptr_ctrl #(.BUF_CNT(3), .ADDR_W(32), .FRAME_BYTES(STRIDE)) dut3 (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .wr_done_stb_i  (wr_done),
        .rd_start_stb_i (rd_start),
        .wr_idx_o       (wr_idx_s[0]),
        .rd_idx_o       (rd_idx_s[0]),
        .wr_addr_o      (wr_addr_s[0]),
        .rd_addr_o      (rd_addr_s[0]),
`ifdef FB_DROP_CNT_EN
        .drop_cnt_o     (drop_cnt_s[0]),
`endif
        .new_frame_o    (new_frame_s[0])
    );

    fb_buf_ptr_ctrl #(.BUF_CNT(4), .ADDR_W(32), .FRAME_BYTES(STRIDE)) dut4 (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .wr_done_stb_i  (wr_done),
        .rd_start_stb_i (rd_start),
        .wr_idx_o       (wr_idx_s[1]),
        .rd_idx_o       (rd_idx_s[1]),
        .wr_addr_o      (wr_addr_s[1]),
        .rd_addr_o      (rd_addr_s[1]),
`ifdef FB_DROP_CNT_EN
        .drop_cnt_o     (drop_cnt_s[1]),
`endif
        .new_frame_o    (new_frame_s[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int lowest_free(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) begin
            if (i != x && i != y) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int c, input bit wd, input bit rs, input bit rn);
        int nf;
        if (!rn) begin
            m_wr[c] = 1; m_rd[c] = 0; m_latest[c] = 0; m_valid[c] = 0; m_drops[c] = 0;
        end else if (wd && rs) begin
            if (m_valid[c] && m_drops[c] < 16'hFFFF) m_drops[c]++;
            nf = lowest_free(buf_cnt[c], m_wr[c], m_wr[c]);
            m_rd[c]    = m_wr[c];
            m_valid[c] = 0;
            m_wr[c]    = nf;
        end else if (wd) begin
            if (m_valid[c] && m_drops[c] < 16'hFFFF) m_drops[c]++;
            nf = lowest_free(buf_cnt[c], m_rd[c], m_wr[c]);
            m_latest[c] = m_wr[c];
            m_valid[c]  = 1;
            m_wr[c]     = nf;
        end else if (rs && m_valid[c]) begin
            m_rd[c]    = m_latest[c];
            m_valid[c] = 0;
        end
    endtask

    task automatic compare_model(input int c);
        string n;
        n = (c == 0) ? "b3" : "b4";
        checkOutput({n, "_wr_idx"},    32'(wr_idx_s[c]),    32'(m_wr[c]));
        checkOutput({n, "_rd_idx"},    32'(rd_idx_s[c]),    32'(m_rd[c]));
        checkOutput({n, "_wr_addr"},   wr_addr_s[c],        32'(m_wr[c]) * STRIDE);
        checkOutput({n, "_rd_addr"},   rd_addr_s[c],        32'(m_rd[c]) * STRIDE);
        checkOutput({n, "_new_frame"}, 32'(new_frame_s[c]), 32'(m_valid[c]));
`ifdef FB_DROP_CNT_EN
        checkOutput({n, "_drop_cnt"},  32'(drop_cnt_s[c]),  32'(m_drops[c]));
`endif
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic applyStimulus(input bit wd, input bit rs, input bit rn);
        @(negedge clk);
        wr_done  = wd;
        rd_start = rs;
        rst_n    = rn;
        @(posedge clk);
        model_step(0, wd, rs, rn);
        model_step(1, wd, rs, rn);
        #1;
        compare_model(0);
        compare_model(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        wr_done  = 1'b0;
        rd_start = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);

        idle(5);
        checkOutput("rst_wr_idx",  32'(wr_idx_s[0]),    32'd1);
        checkOutput("rst_rd_idx",  32'(rd_idx_s[0]),    32'd0);
        checkOutput("rst_wr_addr", wr_addr_s[0],        32'h0020_0000);
        checkOutput("rst_rd_addr", rd_addr_s[0],        32'h0);
        checkOutput("rst_new",     32'(new_frame_s[0]), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("wd_wr_idx", 32'(wr_idx_s[0]),    32'd2);
        checkOutput("wd_new",    32'(new_frame_s[0]), 32'd1);
        idle(8);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rs_rd_idx",  32'(rd_idx_s[0]),    32'd1);
        checkOutput("rs_rd_addr", rd_addr_s[0],        32'h0020_0000);
        checkOutput("rs_new",     32'(new_frame_s[0]), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rep_rd_idx",  32'(rd_idx_s[0]), 32'd1);
        checkOutput("rep_rd_addr", rd_addr_s[0],     32'h0020_0000);
        checkOutput("rep_wr_idx",  32'(wr_idx_s[0]), 32'd2);

        applyStimulus(1'b0, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("dbl1_wr_idx", 32'(wr_idx_s[0]), 32'd2);
        idle(4);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("dbl2_wr_idx", 32'(wr_idx_s[0]),    32'd1);
        checkOutput("dbl2_new",    32'(new_frame_s[0]), 32'd1);
`ifdef FB_DROP_CNT_EN
        checkOutput("dbl2_drop",   32'(drop_cnt_s[0]),  32'd1);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("dbl_latest",  32'(rd_idx_s[0]), 32'd2);

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("fwd_rd_idx", 32'(rd_idx_s[0]),    32'd1);
        checkOutput("fwd_wr_idx", 32'(wr_idx_s[0]),    32'd0);
        checkOutput("fwd_new",    32'(new_frame_s[0]), 32'd0);
        checkOutput("fwd4_wr_idx", 32'(wr_idx_s[1]),   32'd0);

        for (int i = 0; i < 10000; i++) begin
            applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 499) != 0));
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/fb_buf_ptr_ctrl.md
Name: fb_buf_ptr_ctrl

Overview:
Frame-buffer pointer manager in the read (video-out) clock domain, directly downstream of the strobe CDC stage. Consumes the write-side "frame written" strobe after it is resynchronised, plus the local "read frame start" strobe. Implements N-buffer (triple by default) rotation so the writer never targets the buffer being read. Outputs the buffer indices and base addresses for the write and read DMA engines.

Parameters:
BUF_CNT, 3, number of frame buffers; must be >= 3
ADDR_W, 32, width of base-address outputs
FRAME_BYTES, 32'h0020_0000, byte stride between consecutive buffers
IDX_W, $clog2(BUF_CNT), index width (derived, not overridable)

Ports:
clk_i  input  1  read-domain clock
rst_n_i  input  1  synchronous active-low reset
wr_done_stb_i  input  1  one-cycle strobe: writer finished current buffer (output of strobe CDC)
rd_start_stb_i  input  1  one-cycle strobe: reader starting a new frame
wr_idx_o  output  IDX_W  buffer the writer must fill
rd_idx_o  output  IDX_W  buffer the reader must scan
wr_addr_o  output  ADDR_W  wr_idx_o * FRAME_BYTES
rd_addr_o  output  ADDR_W  rd_idx_o * FRAME_BYTES
new_frame_o  output  1  a completed, not-yet-read frame is pending (latest_valid)

Behaviour:
- One clock (clk_i); reset synchronous, active-low (rst_n_i). All state updates on posedge clk_i.
- Internal state: wr_idx, rd_idx, latest_idx, latest_valid.
- Reset values: wr_idx=1, rd_idx=0, latest_idx=0, latest_valid=0. So wr_idx_o=1, rd_idx_o=0, wr_addr_o=FRAME_BYTES, rd_addr_o=0, new_frame_o=0.
- All outputs are registered. Indices and addresses update together, 1 cycle after the strobe. Address registers are loaded from next-index*FRAME_BYTES, truncated to ADDR_W. An address is never one cycle stale relative to its index.
- free(x,y) = lowest index in 0..BUF_CNT-1 not equal to x or y. It always exists because BUF_CNT>=3.
- wr_done only:
  - latest_idx<=wr_idx, latest_valid<=1
  - wr_idx<=free(rd_idx, wr_idx)
  - the previously latest frame, if still valid, is discarded (dropped)
- rd_start only:
  - if latest_valid: rd_idx<=latest_idx, latest_valid<=0
  - otherwise rd_idx is held (the reader repeats the frame)
  - wr_idx unchanged
- Both strobes in the same cycle (forwarding):
  - rd_idx<=wr_idx (the frame just written), latest_valid<=0
  - wr_idx<=free(wr_idx, wr_idx), i.e. the lowest index != old wr_idx
  - an old valid latest is dropped
- Invariants checked by assertion: wr_idx!=rd_idx always; when latest_valid, latest_idx differs from both wr_idx and rd_idx.
- Strobes are assumed single-cycle. A strobe held high is treated as one event per cycle, with no extra protection.
- Reset asserted mid-frame returns to the reset values on the next edge, regardless of strobes.

Optional Feature:
FB_DROP_CNT_EN
- With it:
  - adds port drop_cnt_o, output, 16 bits, saturating count of dropped frames (reset 0)
  - increments on wr_done_stb_i when latest_valid=1 and the old latest is not consumed that cycle (covers both wr_done-only and simultaneous cases)
  - holds at 16'hFFFF
- Without it: port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Package fb_pkg: BUF_CNT default, FRAME_BYTES default, typedef buf_idx_t (logic [IDX_W-1:0]), drop-counter width constant.
- One sub-module, fb_free_idx_find: combinational priority finder taking two excluded indices and returning the lowest free index. Parameterised by BUF_CNT, reused by the write side later.

Test Plan:
- Reset release, no strobes -> wr_idx_o=1, rd_idx_o=0, wr_addr_o=32'h0020_0000, rd_addr_o=0, new_frame_o=0.
- wr_done at cycle 10 -> cycle 11: wr_idx_o=2, new_frame_o=1. rd_start at cycle 20 -> cycle 21: rd_idx_o=1, rd_addr_o=32'h0020_0000, new_frame_o=0.
- rd_start with new_frame_o=0 -> rd_idx_o and rd_addr_o unchanged, wr_idx_o unchanged.
- wr_done twice (cycles 10 and 15), no rd_start -> wr_idx_o 1→2→1, latest=2. With FB_DROP_CNT_EN, drop_cnt_o=1.
- wr_done and rd_start same cycle from reset -> next cycle rd_idx_o=1, wr_idx_o=0, new_frame_o=0.
- 10k cycles of random strobes, BUF_CNT=3 and 4 -> invariant assertions never fire. Drop count matches the scoreboard model. Reset pulsed mid-run restores reset values on the next edge.
